// File: rtl/tilegame_pkg.sv
// ============================================================================
// Module      : tilegame_pkg
// Description : Shared types, constants and helpers for the tile memory game.
//               Holds the game state enum, board geometry, display codes and
//               the tile value / selector decode functions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tilegame_pkg;

  localparam int NUM_TILES = 10;
  localparam int NUM_PAIRS = 5;

  localparam logic [6:0] HEX_BLANK = 7'h7F;
  localparam logic [6:0] HEX_DONE  = 7'b0100001;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PICK1 = 3'd1,
    ST_PICK2 = 3'd2,
    ST_SHOW  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Value of tile idx for a board rotated by off: base[(idx+off) mod 10],
  // where base[p] = (p>>1)+1 gives the 1,1,2,2,...,5,5 pair layout.
  function automatic logic [3:0] tile_value(input logic [3:0] idx,
                                            input logic [3:0] off);
    logic [4:0] pos;
    pos = {1'b0, idx} + {1'b0, off};
    if (pos >= 5'd10) pos = pos - 5'd10;
    return {1'b0, pos[3:1]} + 4'd1 + {3'd0, 1'b0 & pos[4] & pos[0]};
  endfunction

  // Index of the highest set switch; 0 when nothing is set (validity is
  // checked separately with a reduction OR).
  function automatic logic [3:0] sel_index(input logic [9:0] sw);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < NUM_TILES; i++) begin
      if (sw[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hex7seg.sv
// ============================================================================
// Module      : hex7seg
// Description : Decimal digit to active-low seven-segment decoder.
//               Codes 10..15 produce a blank digit.
// Ports       : i_val [3:0] - digit value 0..9
//               o_seg [6:0] - segments, bit0 = a .. bit6 = g, active-low
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex7seg
  import tilegame_pkg::*;
(
  input  logic [3:0] i_val,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = HEX_BLANK;
    case (i_val)
      4'd0: o_seg = 7'b1000000;
      4'd1: o_seg = 7'b1111001;
      4'd2: o_seg = 7'b0100100;
      4'd3: o_seg = 7'b0110000;
      4'd4: o_seg = 7'b0011001;
      4'd5: o_seg = 7'b0010010;
      4'd6: o_seg = 7'b0000010;
      4'd7: o_seg = 7'b1111000;
      4'd8: o_seg = 7'b0000000;
      4'd9: o_seg = 7'b0010000;
      default: o_seg = HEX_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/tilegame.sv
// ============================================================================
// Module      : tilegame
// Description : Ten-tile pair-matching memory game for a DE-class board.
//               Board layout is a rotation of 1,1,2,2,..,5,5 chosen from a
//               free-running LFSR when a new game starts.
// Ports       : CLOCK_50  - system clock, rising edge
//               KEY[0]    - asynchronous active-low reset
//               KEY[3:1]  - active-low buttons: new game / first pick /
//                           second pick
//               SW[9:0]   - tile selector (highest set bit wins)
//               LEDR[9:0] - matched tiles
//               HEX0/HEX1 - first / second pick value
//               HEX2      - score, HEX3 - 'd' when finished
//               HEX5:HEX4 - move count, BCD, saturating at 99
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tilegame
  import tilegame_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  logic w_rst_n;
  assign w_rst_n = KEY[0];

  // --------------------------------------------------------------------------
  // Input synchronizers and press detection
  // --------------------------------------------------------------------------
  logic [2:0] r_key_s1, r_key_s2, r_key_d;
  logic [9:0] r_sw_s1, r_sw_s2;

  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_key_s1 <= 3'b111;
      r_key_s2 <= 3'b111;
      r_key_d  <= 3'b111;
      r_sw_s1  <= 10'd0;
      r_sw_s2  <= 10'd0;
    end else begin
      r_key_s1 <= KEY[3:1];
      r_key_s2 <= r_key_s1;
      r_key_d  <= r_key_s2;
      r_sw_s1  <= SW;
      r_sw_s2  <= r_sw_s1;
    end
  end

  logic [2:0] w_fall;
  logic       w_ev_new, w_ev_p1, w_ev_p2;

  // One event per 1->0 transition, so holding a button does nothing more.
  assign w_fall   = r_key_d & ~r_key_s2;
  assign w_ev_new = w_fall[0];
  assign w_ev_p1  = w_fall[1] & ~w_fall[0];
  assign w_ev_p2  = w_fall[2] & ~w_fall[1] & ~w_fall[0];

  // --------------------------------------------------------------------------
  // Game state
  // --------------------------------------------------------------------------
  state_t     r_state, w_state_n;
  logic [7:0] r_lfsr;
  logic [3:0] r_offset, w_offset_n;
  logic [9:0] r_matched, w_matched_n;
  logic [2:0] r_score, w_score_n;
  logic [3:0] r_mv_tens, w_mv_tens_n;
  logic [3:0] r_mv_ones, w_mv_ones_n;
  logic [3:0] r_first, w_first_n;
  logic [3:0] r_h0_val, w_h0_val_n;
  logic       r_h0_on, w_h0_on_n;
  logic [3:0] r_h1_val, w_h1_val_n;
  logic       r_h1_on, w_h1_on_n;

  // Selection decode against the synchronized switches.
  logic [3:0] w_sel_idx, w_sel_val, w_first_val;
  logic [9:0] w_sel_oh, w_first_oh;
  logic       w_sel_ok;

  assign w_sel_idx   = sel_index(r_sw_s2);
  assign w_sel_oh    = 10'd1 << w_sel_idx;
  assign w_first_oh  = 10'd1 << r_first;
  assign w_sel_ok    = (|r_sw_s2) && !(|(w_sel_oh & r_matched));
  assign w_sel_val   = tile_value(w_sel_idx, r_offset);
  assign w_first_val = tile_value(r_first, r_offset);

  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state   <= ST_IDLE;
      r_lfsr    <= SEED;
      r_offset  <= 4'd0;
      r_matched <= 10'd0;
      r_score   <= 3'd0;
      r_mv_tens <= 4'd0;
      r_mv_ones <= 4'd0;
      r_first   <= 4'd0;
      r_h0_val  <= 4'd0;
      r_h0_on   <= 1'b0;
      r_h1_val  <= 4'd0;
      r_h1_on   <= 1'b0;
    end else begin
      // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, runs every cycle.
      r_lfsr    <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      r_state   <= w_state_n;
      r_offset  <= w_offset_n;
      r_matched <= w_matched_n;
      r_score   <= w_score_n;
      r_mv_tens <= w_mv_tens_n;
      r_mv_ones <= w_mv_ones_n;
      r_first   <= w_first_n;
      r_h0_val  <= w_h0_val_n;
      r_h0_on   <= w_h0_on_n;
      r_h1_val  <= w_h1_val_n;
      r_h1_on   <= w_h1_on_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_offset_n  = r_offset;
    w_matched_n = r_matched;
    w_score_n   = r_score;
    w_mv_tens_n = r_mv_tens;
    w_mv_ones_n = r_mv_ones;
    w_first_n   = r_first;
    w_h0_val_n  = r_h0_val;
    w_h0_on_n   = r_h0_on;
    w_h1_val_n  = r_h1_val;
    w_h1_on_n   = r_h1_on;

    if (w_ev_new) begin
      w_offset_n  = 4'(r_lfsr % 8'd10);
      w_matched_n = 10'd0;
      w_score_n   = 3'd0;
      w_mv_tens_n = 4'd0;
      w_mv_ones_n = 4'd0;
      w_first_n   = 4'd0;
      w_h0_on_n   = 1'b0;
      w_h1_on_n   = 1'b0;
      w_state_n   = ST_PICK1;
    end else begin
      case (r_state)
        // SHOW behaves like PICK1 for a first pick; it only differs in
        // keeping the mismatched pair on display until that happens.
        ST_PICK1, ST_SHOW, ST_PICK2: begin
          if (w_ev_p1 && w_sel_ok) begin
            w_first_n  = w_sel_idx;
            w_h0_val_n = w_sel_val;
            w_h0_on_n  = 1'b1;
            w_h1_on_n  = 1'b0;
            w_state_n  = ST_PICK2;
          end else if (w_ev_p2 && w_sel_ok && (r_state == ST_PICK2) &&
                       (w_sel_idx != r_first)) begin
            w_h1_val_n = w_sel_val;
            w_h1_on_n  = 1'b1;
            if (!(r_mv_tens == 4'd9 && r_mv_ones == 4'd9)) begin
              if (r_mv_ones == 4'd9) begin
                w_mv_ones_n = 4'd0;
                w_mv_tens_n = r_mv_tens + 4'd1;
              end else begin
                w_mv_ones_n = r_mv_ones + 4'd1;
              end
            end
            if (w_sel_val == w_first_val) begin
              w_matched_n = r_matched | w_sel_oh | w_first_oh;
              w_score_n   = r_score + 3'd1;
              w_state_n   = (r_score == 3'(NUM_PAIRS - 1)) ? ST_DONE : ST_PICK1;
            end else begin
              w_state_n = ST_SHOW;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Displays
  // --------------------------------------------------------------------------
  logic [6:0] w_seg0, w_seg1;

  hex7seg u_hex0 (.i_val(r_h0_val),           .o_seg(w_seg0));
  hex7seg u_hex1 (.i_val(r_h1_val),           .o_seg(w_seg1));
  hex7seg u_hex2 (.i_val({1'b0, r_score}),    .o_seg(HEX2));
  hex7seg u_hex4 (.i_val(r_mv_ones),          .o_seg(HEX4));
  hex7seg u_hex5 (.i_val(r_mv_tens),          .o_seg(HEX5));

  assign HEX0 = r_h0_on ? w_seg0 : HEX_BLANK;
  assign HEX1 = r_h1_on ? w_seg1 : HEX_BLANK;
  assign HEX3 = (r_state == ST_DONE) ? HEX_DONE : HEX_BLANK;
  assign LEDR = r_matched;

endmodule

`default_nettype wire

// File: tb/tb_tilegame.sv
`default_nettype none

module tb_tilegame;

  localparam logic [6:0] SB = 7'h7F;
  localparam logic [6:0] SD = 7'h21;
  localparam logic [6:0] S0 = 7'h40;
  localparam logic [6:0] S1 = 7'h79;
  localparam logic [6:0] S2 = 7'h24;
  localparam logic [6:0] S3 = 7'h30;
  localparam logic [6:0] S4 = 7'h19;
  localparam logic [6:0] S5 = 7'h12;
  localparam logic [6:0] S6 = 7'h02;
  localparam logic [6:0] S9 = 7'h10;

  logic       clk = 1'b0;
  logic [3:0] key;
  logic [9:0] sw;
  logic [9:0] ledr;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;

  always #10 clk = ~clk;

  tilegame dut (
    .CLOCK_50(clk),
    .KEY     (key),
    .SW      (sw),
    .LEDR    (ledr),
    .HEX0    (hex0),
    .HEX1    (hex1),
    .HEX2    (hex2),
    .HEX3    (hex3),
    .HEX4    (hex4),
    .HEX5    (hex5)
  );

  function automatic logic [7:0] lstep(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Reference shuffle LFSR, reset and clocked alongside the design.
  logic [7:0] m;
  always @(posedge clk or negedge key[0]) begin
    if (!key[0]) m <= 8'hA5;
    else         m <= lstep(m);
  end

  typedef struct {
    int         k;
    logic [9:0] sw;
    logic [9:0] led;
    logic [6:0] h0, h1, h2, h3, h4, h5;
  } vec_t;

  vec_t v[20];
  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(input int k, input logic [9:0] s, input logic [9:0] l,
                              input logic [6:0] a, input logic [6:0] b, input logic [6:0] c,
                              input logic [6:0] d, input logic [6:0] e, input logic [6:0] f);
    vec_t r;
    r.k = k; r.sw = s; r.led = l;
    r.h0 = a; r.h1 = b; r.h2 = c; r.h3 = d; r.h4 = e; r.h5 = f;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [9:0] el,
                     input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2,
                     input logic [6:0] e3, input logic [6:0] e4, input logic [6:0] e5);
    n_vec++;
    if ({ledr, hex0, hex1, hex2, hex3, hex4, hex5} !== {el, e0, e1, e2, e3, e4, e5}) begin
      n_err++;
      $display("FAIL %s: got LEDR=%h H0=%h H1=%h H2=%h H3=%h H4=%h H5=%h, want LEDR=%h H0=%h H1=%h H2=%h H3=%h H4=%h H5=%h",
               nm, ledr, hex0, hex1, hex2, hex3, hex4, hex5, el, e0, e1, e2, e3, e4, e5);
    end
  endtask

  task automatic press(input int k, input logic [9:0] s);
    @(negedge clk);
    sw = s;
    repeat (3) @(negedge clk);
    key[k] = 1'b0;
    repeat (4) @(negedge clk);
    key[k] = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Press KEY[1] at the moment that makes the captured offset equal off.
  // The press reaches the game logic two edges after it is driven.
  task automatic new_game(input int off);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 600 && !hit; i++) begin
      @(negedge clk);
      if ((lstep(lstep(m)) % 8'd10) == 8'(off)) begin
        key[1] = 1'b0;
        hit = 1'b1;
      end
    end
    if (!hit) begin
      n_vec++;
      n_err++;
      $display("FAIL new_game: offset %0d not reachable, got none, want one", off);
    end
    repeat (4) @(negedge clk);
    key[1] = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    key = 4'b1110;
    sw  = 10'd0;

    // Board with offset 0: tiles 0..9 = 1,1,2,2,3,3,4,4,5,5
    v[0]  = mk(2, 10'h002, 10'h000, S1, SB, S0, SB, S0, S0);
    v[1]  = mk(3, 10'h006, 10'h000, S1, S2, S0, SB, S1, S0);
    v[2]  = mk(2, 10'h000, 10'h000, S1, S2, S0, SB, S1, S0);
    v[3]  = mk(3, 10'h008, 10'h000, S1, S2, S0, SB, S1, S0);
    v[4]  = mk(2, 10'h004, 10'h000, S2, SB, S0, SB, S1, S0);
    v[5]  = mk(2, 10'h001, 10'h000, S1, SB, S0, SB, S1, S0);
    v[6]  = mk(3, 10'h001, 10'h000, S1, SB, S0, SB, S1, S0);
    v[7]  = mk(3, 10'h002, 10'h003, S1, S1, S1, SB, S2, S0);
    v[8]  = mk(3, 10'h008, 10'h003, S1, S1, S1, SB, S2, S0);
    v[9]  = mk(2, 10'h001, 10'h003, S1, S1, S1, SB, S2, S0);
    v[10] = mk(2, 10'h00C, 10'h003, S2, SB, S1, SB, S2, S0);
    v[11] = mk(3, 10'h004, 10'h00F, S2, S2, S2, SB, S3, S0);
    v[12] = mk(2, 10'h010, 10'h00F, S3, SB, S2, SB, S3, S0);
    v[13] = mk(3, 10'h020, 10'h03F, S3, S3, S3, SB, S4, S0);
    v[14] = mk(2, 10'h040, 10'h03F, S4, SB, S3, SB, S4, S0);
    v[15] = mk(3, 10'h080, 10'h0FF, S4, S4, S4, SB, S5, S0);
    v[16] = mk(2, 10'h100, 10'h0FF, S5, SB, S4, SB, S5, S0);
    v[17] = mk(3, 10'h200, 10'h3FF, S5, S5, S5, SD, S6, S0);
    v[18] = mk(3, 10'h200, 10'h3FF, S5, S5, S5, SD, S6, S0);
    v[19] = mk(2, 10'h001, 10'h3FF, S5, S5, S5, SD, S6, S0);

    repeat (5) @(negedge clk);
    chk("reset_held", 10'h000, SB, SB, S0, SB, S0, S0);
    key[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("after_reset", 10'h000, SB, SB, S0, SB, S0, S0);

    new_game(0);
    chk("new_game", 10'h000, SB, SB, S0, SB, S0, S0);
    for (int i = 0; i < 20; i++) begin
      press(v[i].k, v[i].sw);
      chk($sformatf("vec%0d", i), v[i].led, v[i].h0, v[i].h1, v[i].h2, v[i].h3, v[i].h4, v[i].h5);
    end

    // Rotated board, including wrap-around of the index.
    new_game(3);
    press(2, 10'h002);
    chk("off3_tile1", 10'h000, S3, SB, S0, SB, S0, S0);
    press(2, 10'h200);
    chk("off3_tile9", 10'h000, S2, SB, S0, SB, S0, S0);

    // Long hold gives one event; the switch change mid-hold must not re-pick.
    new_game(0);
    @(negedge clk);
    sw = 10'h001;
    repeat (3) @(negedge clk);
    key[2] = 1'b0;
    repeat (10) @(negedge clk);
    sw = 10'h004;
    repeat (90) @(negedge clk);
    key[2] = 1'b1;
    repeat (4) @(negedge clk);
    chk("held_key2", 10'h000, S1, SB, S0, SB, S0, S0);

    // New game and first pick on the same cycle: only the new game happens.
    key[1] = 1'b0;
    key[2] = 1'b0;
    repeat (4) @(negedge clk);
    key[1] = 1'b1;
    key[2] = 1'b1;
    repeat (4) @(negedge clk);
    chk("key1_key2_same", 10'h000, SB, SB, S0, SB, S0, S0);

    // Move counter: BCD carry and saturation.
    new_game(0);
    press(2, 10'h001);
    for (int i = 0; i < 10; i++) begin
      press(3, 10'h004);
      press(2, 10'h001);
    end
    chk("moves_10", 10'h000, S1, SB, S0, SB, S0, S1);
    for (int i = 0; i < 91; i++) begin
      press(3, 10'h004);
      if (i != 90) press(2, 10'h001);
    end
    chk("moves_sat99", 10'h000, S1, S2, S0, SB, S9, S9);

    // Reset mid-game drops everything.
    key[0] = 1'b0;
    repeat (2) @(negedge clk);
    key[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_midgame", 10'h000, SB, SB, S0, SB, S0, S0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tilegame.md
TILEGAME -- requirements
Module: tilegame

Interface
REQ-001 SHALL have parameter SEED, default 8'hA5, reset value of the internal 8-bit shuffle LFSR (must be non-zero).
REQ-002 SHALL have port CLOCK_50  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port KEY[0]  input  1  reset, asynchronous and active-low (pushbutton).
REQ-004 SHALL have port KEY[3:1]  input  3  active-low pushbuttons: KEY[1] new game, KEY[2] pick first tile, KEY[3] pick second tile.
REQ-005 SHALL have port SW  input  10  tile selector; selected tile = index of highest set bit; no bit set = no selection.
REQ-006 SHALL have port LEDR  output  10  bit i lit = tile i matched.
REQ-007 SHALL have ports HEX0..HEX5  output  7 each  active-low seven-segment digits, bit0=a .. bit6=g; blank = 7'h7F.

Function
REQ-008 SHALL pass SW and KEY[3:1] through two-flop synchronizers; a press SHALL be a 1->0 edge of the synchronized key, giving exactly one event per press regardless of hold time.
REQ-009 SHALL resolve same-cycle presses with priority KEY[1] > KEY[2] > KEY[3]; lower-priority events that cycle are dropped.
REQ-010 SHALL hold 10 tiles forming 5 pairs; base value of position p = (p>>1)+1, i.e. 1,1,2,2,3,3,4,4,5,5.
REQ-011 SHALL run a free-running 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, every cycle.
REQ-012 On KEY[1] press in any state: capture offset = LFSR mod 10; tile i value = base[(i+offset) mod 10]; clear matched, moves, score, picks; go to PICK1.
REQ-013 SHALL implement states IDLE, PICK1, PICK2, SHOW, DONE; IDLE is exited only by KEY[1].
REQ-014 PICK1, KEY[2] with valid unmatched selection: first=sel, HEX0 shows its value, HEX1 blank, go PICK2; otherwise ignored. KEY[3] in PICK1 ignored.
REQ-015 PICK2, KEY[2] with valid unmatched selection: replaces first pick, stays PICK2.
REQ-016 PICK2, KEY[3] with valid unmatched selection != first: second=sel, HEX1 shows its value, moves incremented; else ignored.
REQ-017 On equal values: both matched bits set in the same cycle, score+1; go DONE if score reaches 5, else PICK1 (HEX0/HEX1 hold values until next pick).
REQ-018 On unequal values: go SHOW; both values stay displayed until next KEY[2] press, which is then processed as a PICK1 press (HEX1 blanked).
REQ-019 DONE: LEDR=10'h3FF, HEX3 shows 'd' (7'b0100001), KEY[2]/KEY[3] ignored until KEY[1].
REQ-020 HEX2 SHALL show score 0..5; HEX5:HEX4 SHALL show moves as two BCD digits, saturating at 99.
REQ-021 HEX3 SHALL be blank outside DONE; all registered outputs update the cycle after the causing press event.

Reset
REQ-022 While KEY[0]=0: state IDLE, LFSR=SEED, matched=0, score=0, moves=0, picks cleared, synchronizers =1 (released).
REQ-023 Reset outputs: LEDR=0, HEX0/HEX1/HEX3 blank, HEX2='0', HEX4='0', HEX5='0'; reset mid-game discards all progress.

Structure
REQ-024 Package tilegame_pkg SHALL hold the state enum, NUM_TILES=10, NUM_PAIRS=5, HEX_BLANK=7'h7F, HEX_DONE=7'b0100001.
REQ-025 SHALL instantiate a sub-module hex7seg (4-bit value -> active-low segments, 0-9 decimal) for every numeric digit.

Verification
REQ-026 Reset with KEY[0]=0 then release -> LEDR=0, HEX2/HEX4/HEX5='0' (7'b1000000), HEX0/HEX1 blank.
REQ-027 KEY[1] press, SW=10'b0000000010, KEY[2] press -> HEX0 = value of tile 1 per offset, state PICK2.
REQ-028 SW=10'b0000000110, KEY[3] press -> tile 2 picked; if values equal LEDR[2:1]=2'b11 and HEX2='1', else LEDR=0, HEX5:HEX4='01'.
REQ-029 After mismatch, KEY[2] press -> HEX1 blank, HEX0 shows new first pick; SW=0 with KEY[2] -> no change.
REQ-030 Force offset by timing KEY[1]; match all 5 pairs -> LEDR=10'h3FF, HEX2='5', HEX3 shows 'd'; further KEY[3] ignored.
REQ-031 KEY[2] held low 100 cycles -> exactly one pick event; KEY[1] and KEY[2] same cycle -> new game only.
